das_ram: RTL and testbench

DAS_RAM -- requirements
Module: das_ram

---
 rtl/das_ram_if.sv | 24 ++
 rtl/das_ram.sv | 99 +++++++++
 tb/tb_das_ram.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/das_ram_if.sv
// Bundled request/response signals of the das_ram access port.
// Master drives the request side; slave (the RAM) returns status and data.
interface das_ram_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  MOC;
  logic                  Enable;
  logic                  MOV;
  logic                  ReadWrite;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] DataIn;

  modport master (
    output Enable, ReadWrite, Address, DataIn,
    input  DataOut, MOC, MOV
  );

  modport slave (
    input  Enable, ReadWrite, Address, DataIn,
    output DataOut, MOC, MOV
  );
endinterface

// File: rtl/das_ram.sv
// Single-port RAM behind an IDLE/BUSY/DONE request handshake.
// Requests are captured in IDLE, committed on the BUSY exit edge, and acknowledged in DONE.
module das_ram #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
) (
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  MOC,
  input  logic                  Enable,
  output logic                  MOV,
  input  logic                  ReadWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  clk,
  input  logic                  rst_n
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rw;
  logic [DATA_WIDTH-1:0] r_din;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_moc;
  logic                  r_mov;
  logic                  w_capture;
  logic                  w_commit;

  // Storage is not reset so backdoor-preloaded contents survive rst_n.
  logic [DATA_WIDTH-1:0] Mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // DONE only exits once Enable is seen low, so a held Enable cannot retrigger.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      IDLE: begin
        if (Enable) begin
          w_next    = BUSY;
          w_capture = 1'b1;
        end
      end
      BUSY: begin
        w_next   = DONE;
        w_commit = 1'b1;
      end
      DONE: begin
        if (!Enable) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rw   <= 1'b0;
      r_din  <= '0;
    end else if (w_capture) begin
      r_addr <= Address;
      r_rw   <= ReadWrite;
      r_din  <= DataIn;
    end
  end

  // Status flags are registered against the next state so they align with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_moc  <= 1'b0;
      r_mov  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_moc <= (w_next == DONE);
      r_mov <= (w_next == DONE) && r_rw;
      if (w_commit && r_rw) r_dout <= Mem[r_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && !r_rw) Mem[r_addr] <= r_din;
  end

  assign DataOut = r_dout;
  assign MOC     = r_moc;
  assign MOV     = r_mov;
endmodule

// File: tb/tb_das_ram.sv
// Scoreboard bench for das_ram: driver pushes expected DONE responses, monitor pops and compares.
module tb_das_ram;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef struct {
    logic [DW-1:0] dout;
    logic          mov;
    int            len;
  } exp_t;

  logic clk;
  logic rst_n;
  das_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  das_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .DataOut  (bus.DataOut),
    .MOC      (bus.MOC),
    .Enable   (bus.Enable),
    .MOV      (bus.MOV),
    .ReadWrite(bus.ReadWrite),
    .Address  (bus.Address),
    .DataIn   (bus.DataIn),
    .clk      (clk),
    .rst_n    (rst_n)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  exp_t          q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per DONE episode; also measures MOC pulse length.
  initial begin
    exp_t cur;
    bit   in_done;
    int   len;
    in_done = 1'b0;
    len     = 0;
    cur     = '{dout: '0, mov: 1'b0, len: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_done = 1'b0;
      end else if (bus.MOC && !in_done) begin
        in_done = 1'b1;
        len     = 1;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(q.size()), 32'd1);
        end else begin
          cur = q.pop_front();
          chk("done_dataout", 32'(bus.DataOut), 32'(cur.dout));
          chk("done_mov", 32'(bus.MOV), 32'(cur.mov));
        end
      end else if (bus.MOC) begin
        len++;
      end else if (in_done) begin
        in_done = 1'b0;
        chk("moc_length", 32'(len), 32'(cur.len));
      end
    end
  end

  // Issue one access with Enable held high across `hold` rising edges.
  task automatic do_op(input bit rw, input int addr, input int data, input int hold);
    exp_t e;
    @(negedge clk);
    bus.Enable    = 1'b1;
    bus.ReadWrite = rw;
    bus.Address   = AW'(addr);
    bus.DataIn    = DW'(data);
    if (rw) begin
      model_dout = model_mem[addr % DEPTH];
    end else begin
      model_mem[addr % DEPTH] = DW'(data);
    end
    e.dout = model_dout;
    e.mov  = rw;
    e.len  = (hold < 2) ? 1 : hold - 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.Address   = AW'($urandom);
    bus.DataIn    = DW'($urandom);
    bus.ReadWrite = 1'($urandom);
    if (hold == 1) bus.Enable = 1'b0;
    @(posedge clk);
    #1;
    chk("moc_latency", 32'(bus.MOC), 32'd1);
    for (int k = 2; k < hold; k++) @(posedge clk);
    #1;
    bus.Enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [DW-1:0] v;
    rst_n         = 1'b0;
    bus.Enable    = 1'b0;
    bus.ReadWrite = 1'b0;
    bus.Address   = '0;
    bus.DataIn    = '0;
    model_dout    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = (i < 10) ? DW'(10 * (i + 1)) : DW'($urandom);
      dut.Mem[i]   = v;
      model_mem[i] = v;
    end
    #2;
    chk("reset_dataout", 32'(bus.DataOut), 32'd0);
    chk("reset_moc", 32'(bus.MOC), 32'd0);
    chk("reset_mov", 32'(bus.MOV), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 10; a++) do_op(1'b1, a, 0, 1);

    do_op(1'b0, 3, 8'hA5, 1);
    do_op(1'b1, 3, 0, 2);
    chk("mem3_after_write", 32'(dut.Mem[3]), 32'(model_mem[3]));

    do_op(1'b0, 511, 8'h3C, 1);
    do_op(1'b1, 511, 0, 1);
    do_op(1'b1, 0, 0, 1);

    do_op(1'b1, 7, 0, 6);
    do_op(1'b1, 2, 0, 1);

    // Reset pulse while a write of 0xFF to address 5 is in BUSY.
    @(negedge clk);
    bus.Enable    = 1'b1;
    bus.ReadWrite = 1'b0;
    bus.Address   = AW'(5);
    bus.DataIn    = 8'hFF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_dataout", 32'(bus.DataOut), 32'd0);
    chk("abort_moc", 32'(bus.MOC), 32'd0);
    chk("abort_mov", 32'(bus.MOV), 32'd0);
    bus.Enable = 1'b0;
    model_dout = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_mem5", 32'(dut.Mem[5]), 32'(model_mem[5]));
    do_op(1'b1, 5, 0, 1);

    for (int n = 0; n < 60; n++) begin
      do_op(1'($urandom), int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(6, 1)));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end
endmodule
